// File: rtl/cu_pkg.sv
// cu_pkg: shared state, opcode and control-field encodings for the multi-cycle control unit
package cu_pkg;
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EX_R     = 4'd2,
    S_EX_I     = 4'd3,
    S_EX_AUIPC = 4'd4,
    S_EX_ADDR  = 4'd5,
    S_MEM_RD   = 4'd6,
    S_MEM_WR   = 4'd7,
    S_WB_ALU   = 4'd8,
    S_WB_MEM   = 4'd9,
    S_EX_BR    = 4'd10,
    S_EX_JAL   = 4'd11,
    S_EX_JALR  = 4'd12,
    S_TRAP     = 4'd15
  } state_t;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] ALU_ADD   = 3'd0;
  localparam logic [2:0] ALU_SUB   = 3'd1;
  localparam logic [2:0] ALU_FUNCT = 3'd2;
  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_J = 3'd4;
  localparam logic [2:0] IMM_U = 3'd5;
  localparam logic [1:0] SRCA_PC    = 2'd0;
  localparam logic [1:0] SRCA_RS1   = 2'd1;
  localparam logic [1:0] SRCA_OLDPC = 2'd2;
  localparam logic [1:0] SRCB_RS2  = 2'd0;
  localparam logic [1:0] SRCB_IMM  = 2'd1;
  localparam logic [1:0] SRCB_FOUR = 2'd2;
  localparam logic [1:0] PC_ALU    = 2'd0;
  localparam logic [1:0] PC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_JALR   = 2'd2;
  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;
  function automatic state_t decode_target(input logic [6:0] op, input logic [2:0] f3);
    case (op)
      OP_R:     return S_EX_R;
      OP_I:     return S_EX_I;
      OP_LW:    return S_EX_ADDR;
      OP_SW:    return S_EX_ADDR;
      OP_B:     return (f3 == F3_BEQ || f3 == F3_BNE) ? S_EX_BR : S_TRAP;
      OP_JAL:   return S_EX_JAL;
      OP_JALR:  return S_EX_JALR;
      OP_AUIPC: return S_EX_AUIPC;
      default:  return S_TRAP;
    endcase
  endfunction
endpackage

// File: rtl/cu_bus_watchdog.sv
// cu_bus_watchdog: counts stalled bus cycles and flags the one that reaches TIMEOUT_CYC
module cu_bus_watchdog #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic busy,
  output logic timeout
);
  localparam int W = $clog2(TIMEOUT_CYC + 1);
  logic [W-1:0] cnt;
  assign timeout = busy && cnt == W'(TIMEOUT_CYC - 1);
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else cnt <= (busy && !timeout) ? cnt + 1'b1 : '0;
endmodule

// File: rtl/control_unit_mc.sv
// control_unit_mc: multi-cycle RV32I control FSM with bus wait handshake, traps and retire count
module control_unit_mc
  import cu_pkg::*;
#(
  parameter int OPCODE_W    = 7,
  parameter int FUNCT_W     = 3,
  parameter int ALUOP_W     = 3,
  parameter int IMMSEL_W    = 3,
  parameter int TIMEOUT_CYC = 255,
  parameter int CNT_W       = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opCode,
  input  logic [FUNCT_W-1:0]  funct,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                IRWrite,
  output logic                PCWrite,
  output logic                BranchEQ,
  output logic                BranchNE,
  output logic [1:0]          PCSrc,
  output logic                HADDR_Sel,
  output logic                MemWrite,
  output logic                MemtoReg,
  output logic [1:0]          ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic [ALUOP_W-1:0]  ALUOp,
  output logic [IMMSEL_W-1:0] immediateSel,
  output logic                RegWrite,
  output logic                trap,
  output logic [1:0]          trap_cause,
  output logic [CNT_W-1:0]    retired,
  output logic [3:0]          state_o
);
  state_t state, next, s;
  logic run, timeout, done;
  cu_bus_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wd (
    .clk(clk), .rst(rst), .busy(mem_req && !mem_ready), .timeout(timeout)
  );
  // run holds every output low until the first edge after reset release
  assign s = run ? state : S_TRAP;
  assign state_o = state;
  assign trap = state == S_TRAP;
  assign mem_req = s inside {S_FETCH, S_MEM_RD, S_MEM_WR};
  assign IRWrite = s == S_FETCH && mem_ready;
  assign PCWrite = (s == S_FETCH && mem_ready) || s inside {S_EX_JAL, S_EX_JALR};
  assign BranchEQ = s == S_EX_BR && funct == F3_BEQ;
  assign BranchNE = s == S_EX_BR && funct == F3_BNE;
  assign PCSrc = s inside {S_EX_BR, S_EX_JAL} ? PC_ALUOUT : s == S_EX_JALR ? PC_JALR : PC_ALU;
  assign HADDR_Sel = s inside {S_MEM_RD, S_MEM_WR};
  assign MemWrite = s == S_MEM_WR;
  assign MemtoReg = s == S_WB_MEM;
  assign RegWrite = s inside {S_WB_ALU, S_WB_MEM, S_EX_JAL, S_EX_JALR};
  assign ALUSrcA = s inside {S_EX_R, S_EX_I, S_EX_ADDR, S_EX_BR} ? SRCA_RS1 :
                   s inside {S_DECODE, S_EX_AUIPC, S_EX_JAL, S_EX_JALR} ? SRCA_OLDPC : SRCA_PC;
  assign ALUSrcB = s inside {S_FETCH, S_EX_JAL, S_EX_JALR} ? SRCB_FOUR :
                   s inside {S_DECODE, S_EX_I, S_EX_AUIPC, S_EX_ADDR} ? SRCB_IMM : SRCB_RS2;
  assign ALUOp = ALUOP_W'(s inside {S_EX_R, S_EX_I} ? ALU_FUNCT : s == S_EX_BR ? ALU_SUB : ALU_ADD);
  assign immediateSel = IMMSEL_W'(s == S_DECODE ? (opCode == OP_JAL ? IMM_J : IMM_B) :
                                  s == S_EX_JAL ? IMM_J :
                                  s == S_EX_AUIPC ? IMM_U :
                                  (s == S_EX_ADDR && opCode == OP_SW) ? IMM_S : IMM_I);
  always_comb begin
    next = state;
    case (state)
      S_FETCH:                            next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE:                           next = decode_target(opCode, funct);
      S_EX_R, S_EX_I, S_EX_AUIPC:         next = S_WB_ALU;
      S_EX_ADDR:                          next = opCode == OP_SW ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:                           next = mem_ready ? S_WB_MEM : S_MEM_RD;
      S_MEM_WR:                           next = mem_ready ? S_FETCH : S_MEM_WR;
      S_WB_ALU, S_WB_MEM, S_EX_BR,
      S_EX_JAL, S_EX_JALR:                next = S_FETCH;
      default:                            next = S_TRAP;
    endcase
    if (timeout) next = S_TRAP;
  end
  // every path back to FETCH leaves a completing state
  assign done = run && state != S_FETCH && next == S_FETCH;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      run        <= 1'b0;
      state      <= S_FETCH;
      trap_cause <= CAUSE_NONE;
      retired    <= '0;
    end else begin
      run <= 1'b1;
      if (run) state <= next;
      if (run && next == S_TRAP && state != S_TRAP) trap_cause <= timeout ? CAUSE_TIMEOUT : CAUSE_ILLEGAL;
      if (done) retired <= retired + 1'b1;
    end
endmodule

// File: tb/tb_control_unit_mc.sv
// tb_control_unit_mc: phase-sequence scoreboard plus hand-computed checks for control_unit_mc
module tb_control_unit_mc;
  typedef struct packed {
    logic mem_req, irw, pcw, beq, bne;
    logic [1:0] pcsrc;
    logic haddr, mw, m2r;
    logic [1:0] srca, srcb;
    logic [2:0] aluop, imm;
    logic rw, trap;
  } ctl_t;
  localparam int P_F = 0, P_D = 1, P_XR = 2, P_XI = 3, P_XU = 4, P_XA = 5, P_MR = 6, P_MW = 7,
                 P_WA = 8, P_WM = 9, P_BR = 10, P_JAL = 11, P_JALR = 12, P_TRAP = 13;
  localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LW = 7'b0000011, SW = 7'b0100011,
                         B = 7'b1100011, JAL = 7'b1101111, JALR = 7'b1100111, AUIPC = 7'b0010111;
  logic clk = 1'b0, rst = 1'b1;
  logic [6:0] opCode = '0;
  logic [2:0] funct = '0;
  logic mem_ready = 1'b0;
  logic mem_req, IRWrite, PCWrite, BranchEQ, BranchNE, HADDR_Sel, MemWrite, MemtoReg, RegWrite, trap;
  logic [1:0] PCSrc, ALUSrcA, ALUSrcB, trap_cause;
  logic [2:0] ALUOp, immediateSel;
  logic [31:0] retired;
  logic [3:0] state_o;
  ctl_t got, cur_ctl;
  logic [1:0] cur_cause, m_cause;
  logic [31:0] cur_ret, m_ret;
  int cur_p, total, bad;
  logic chk = 1'b0;
  control_unit_mc #(.TIMEOUT_CYC(4)) dut (
    .clk(clk), .rst(rst), .opCode(opCode), .funct(funct), .mem_ready(mem_ready),
    .mem_req(mem_req), .IRWrite(IRWrite), .PCWrite(PCWrite), .BranchEQ(BranchEQ),
    .BranchNE(BranchNE), .PCSrc(PCSrc), .HADDR_Sel(HADDR_Sel), .MemWrite(MemWrite),
    .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .immediateSel(immediateSel), .RegWrite(RegWrite), .trap(trap), .trap_cause(trap_cause),
    .retired(retired), .state_o(state_o)
  );
  always #5 clk = ~clk;
  assign got = {mem_req, IRWrite, PCWrite, BranchEQ, BranchNE, PCSrc, HADDR_Sel, MemWrite, MemtoReg,
                ALUSrcA, ALUSrcB, ALUOp, immediateSel, RegWrite, trap};
  // expected control word for one phase of an instruction, straight from the phase table
  function automatic ctl_t exp_ctl(input int p, input logic [6:0] op, input logic [2:0] f3, input logic rdy);
    ctl_t c = '0;
    case (p)
      P_F:    begin c.mem_req = 1; c.srcb = 2; c.irw = rdy; c.pcw = rdy; end
      P_D:    begin c.srca = 2; c.srcb = 1; c.imm = (op == JAL) ? 3'd4 : 3'd2; end
      P_XR:   begin c.srca = 1; c.aluop = 2; end
      P_XI:   begin c.srca = 1; c.srcb = 1; c.aluop = 2; end
      P_XU:   begin c.srca = 2; c.srcb = 1; c.imm = 5; end
      P_XA:   begin c.srca = 1; c.srcb = 1; c.imm = (op == SW) ? 3'd1 : 3'd0; end
      P_MR:   begin c.mem_req = 1; c.haddr = 1; end
      P_MW:   begin c.mem_req = 1; c.haddr = 1; c.mw = 1; end
      P_WA:   c.rw = 1;
      P_WM:   begin c.rw = 1; c.m2r = 1; end
      P_BR:   begin c.srca = 1; c.aluop = 1; c.pcsrc = 1; c.beq = (f3 == 0); c.bne = (f3 == 1); end
      P_JAL:  begin c.imm = 4; c.pcw = 1; c.pcsrc = 1; c.rw = 1; c.srca = 2; c.srcb = 2; end
      P_JALR: begin c.pcw = 1; c.pcsrc = 2; c.rw = 1; c.srca = 2; c.srcb = 2; end
      default: c.trap = 1;
    endcase
    return c;
  endfunction
  always @(negedge clk) if (chk) begin
    total++;
    if (got !== cur_ctl) begin bad++; $display("FAIL ctl phase=%0d got=%h exp=%h t=%0t", cur_p, got, cur_ctl, $time); end
    total++;
    if (trap_cause !== cur_cause) begin bad++; $display("FAIL cause phase=%0d got=%0d exp=%0d t=%0t", cur_p, trap_cause, cur_cause, $time); end
    total++;
    if (retired !== cur_ret) begin bad++; $display("FAIL retired phase=%0d got=%0d exp=%0d t=%0t", cur_p, retired, cur_ret, $time); end
  end
  task automatic lit(input string n, input logic [31:0] g, input logic [31:0] e);
    total++;
    if (g !== e) begin bad++; $display("FAIL %s got=%0h exp=%0h t=%0t", n, g, e, $time); end
  endtask
  task automatic cyc(input int p, input logic [6:0] op, input logic [2:0] f3, input logic rdy);
    @(posedge clk); #1;
    opCode = op; funct = f3; mem_ready = rdy;
    cur_ctl = exp_ctl(p, op, f3, rdy); cur_cause = m_cause; cur_ret = m_ret; cur_p = p;
    chk = 1;
  endtask
  task automatic do_reset();
    chk = 0;
    rst = 0;
    #1;
    lit("rst_mem_req", mem_req, 0);
    lit("rst_memwrite", MemWrite, 0);
    lit("rst_irwrite", IRWrite, 0);
    lit("rst_trap", trap, 0);
    lit("rst_cause", trap_cause, 0);
    lit("rst_retired", retired, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1;
    m_ret = 0;
    m_cause = 0;
  endtask
  task automatic instr(input logic [6:0] op, input logic [2:0] f3, input int fw, input int mw);
    logic trapped = 0;
    repeat (fw) cyc(P_F, op, f3, 0);
    cyc(P_F, op, f3, 1);
    cyc(P_D, op, f3, 1);
    case (op)
      R:     begin cyc(P_XR, op, f3, 1); cyc(P_WA, op, f3, 1); end
      I:     begin cyc(P_XI, op, f3, 1); cyc(P_WA, op, f3, 1); end
      AUIPC: begin cyc(P_XU, op, f3, 1); cyc(P_WA, op, f3, 1); end
      LW:    begin cyc(P_XA, op, f3, 1); repeat (mw) cyc(P_MR, op, f3, 0); cyc(P_MR, op, f3, 1); cyc(P_WM, op, f3, 1); end
      SW:    begin cyc(P_XA, op, f3, 1); repeat (mw) cyc(P_MW, op, f3, 0); cyc(P_MW, op, f3, 1); end
      B:     if (f3 <= 3'd1) cyc(P_BR, op, f3, 1); else trapped = 1;
      JAL:   cyc(P_JAL, op, f3, 1);
      JALR:  cyc(P_JALR, op, f3, 1);
      default: trapped = 1;
    endcase
    if (trapped) begin
      if (m_cause == 0) m_cause = 1;
      for (int i = 0; i < 10; i++) cyc(P_TRAP, op, f3, i[0]);
    end else m_ret++;
  endtask
  initial begin
    #100000;
    $display("FAIL sim_timeout t=%0t", $time);
    $fatal(1);
  end
  initial begin
    total = 0; bad = 0; m_ret = 0; m_cause = 0;
    #2 do_reset();
    cyc(P_F, I, 3'b000, 1); #2 lit("addi_irwrite_c1", IRWrite, 1);
    cyc(P_D, I, 3'b000, 1);
    cyc(P_XI, I, 3'b000, 1);
    cyc(P_WA, I, 3'b000, 1); #2 lit("addi_regwrite_c4", RegWrite, 1);
    m_ret++;
    instr(R, 3'b000, 1, 0); #2 lit("addi_retired", retired, 1);
    instr(AUIPC, 3'b000, 0, 0);
    instr(LW, 3'b010, 0, 3);
    instr(SW, 3'b010, 2, 1);
    instr(B, 3'b000, 0, 0);
    cyc(P_F, B, 3'b001, 1);
    cyc(P_D, B, 3'b001, 1);
    cyc(P_BR, B, 3'b001, 1); #2 lit("bne_branchne", BranchNE, 1); lit("bne_brancheq", BranchEQ, 0);
    m_ret++;
    instr(JAL, 3'b000, 0, 0);
    instr(JALR, 3'b000, 1, 0);
    #2 lit("retired_before_trap", retired, 8);
    instr(B, 3'b100, 0, 0); #2 lit("bad_branch_trap", trap, 1); lit("bad_branch_cause", trap_cause, 1);
    do_reset();
    instr(I, 3'b000, 0, 0);
    cyc(P_F, SW, 3'b010, 1);
    cyc(P_D, SW, 3'b010, 1);
    cyc(P_XA, SW, 3'b010, 1);
    cyc(P_MW, SW, 3'b010, 0);
    #6 do_reset();
    instr(I, 3'b000, 0, 0);
    instr(7'b0000000, 3'b000, 0, 0);
    do_reset();
    for (int i = 0; i < 4; i++) cyc(P_F, I, 3'b000, 0);
    m_cause = 2;
    cyc(P_TRAP, I, 3'b000, 0); #2 lit("timeout_cause_c5", trap_cause, 2); lit("timeout_mem_req", mem_req, 0);
    for (int i = 0; i < 5; i++) cyc(P_TRAP, I, 3'b000, i[0]);
    @(posedge clk); #1 chk = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/control_unit_mc.md
Name: control_unit_mc

Overview:
- Multi-cycle successor to the single-cycle RISC-V control decoder.
- FSM sequences each RV32I instruction over FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK, sharing one ALU and one bus port (program + data + UART-mapped space).
- Adds memory wait-state handshake, bus-timeout trap, illegal-opcode trap and per-class cycle counting.
- Sits between the instruction register / datapath muxes and the bus interface.

Parameters:
- OPCODE_W, 7, opcode field width
- FUNCT_W, 3, funct3 width
- ALUOP_W, 3, ALU operation code width to ALU decoder
- IMMSEL_W, 3, immediate-generator select width
- TIMEOUT_CYC, 255, max wait cycles on mem_ready before trap (≥1)
- CNT_W, 32, width of retired-instruction counter

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset (0 = reset)
- opCode  in  OPCODE_W  from instruction register
- funct  in  FUNCT_W  funct3 from instruction register
- mem_ready  in  1  bus transfer complete this cycle
- mem_req  out  1  bus request; held until mem_ready
- IRWrite  out  1  latch instruction register
- PCWrite  out  1  unconditional PC update
- BranchEQ / BranchNE  out  1 each  conditional PC update qualifiers
- PCSrc  out  2  0=ALU result, 1=ALUOut reg, 2=rs1+imm (JALR, bit0 cleared in datapath)
- HADDR_Sel  out  1  0=PC address, 1=ALUOut data address
- MemWrite  out  1  bus write
- MemtoReg  out  1  writeback from memory data reg
- ALUSrcA  out  2  0=PC, 1=rs1, 2=oldPC
- ALUSrcB  out  2  0=rs2, 1=imm, 2=const 4
- ALUOp  out  ALUOP_W  0=add, 1=sub/compare, 2=funct-decoded
- immediateSel  out  IMMSEL_W  0=I,1=S,2=B,4=J,5=U
- RegWrite  out  1  register-file write enable
- trap  out  1  sticky; illegal opcode or bus timeout
- trap_cause  out  2  0=none,1=illegal opcode,2=bus timeout
- retired  out  CNT_W  instructions completed
- state_o  out  4  current state encoding, debug

Behaviour:
- Reset (rst=0, async): state=FETCH; all control outputs 0; trap=0, trap_cause=0, retired=0, wait counter=0. First fetch request at the first clk edge after rst rises.
- Moore outputs decoded from the state register, except: IRWrite and PCWrite in FETCH, and the MEM_* advance, are qualified by mem_ready (Mealy).
- FETCH: mem_req=1, HADDR_Sel=0, ALUSrcA=0, ALUSrcB=2, ALUOp=0. On mem_ready: IRWrite=1, PCWrite=1, PCSrc=0 → DECODE.
- DECODE: ALUSrcA=2, ALUSrcB=1, immediateSel=2 (precompute branch target into ALUOut). Dispatch on opCode:
  - R → EX_R
  - I-ALU → EX_I
  - LW/SW → EX_ADDR
  - B with funct 000/001 → EX_BR, other funct3 → TRAP
  - JAL → EX_JAL
  - JALR → EX_JALR
  - AUIPC → EX_AUIPC
  - any other opcode → TRAP (cause 1)
- EX_R: ALUSrcA=1, ALUSrcB=0, ALUOp=2 → WB_ALU.
- EX_I: as EX_R but ALUSrcB=1, immediateSel=0 → WB_ALU.
- EX_AUIPC: ALUSrcA=2, ALUSrcB=1, immediateSel=5, ALUOp=0 → WB_ALU.
- EX_ADDR: ALUSrcA=1, ALUSrcB=1, ALUOp=0, immediateSel=0 (LW) or 1 (SW) → MEM_RD or MEM_WR.
- MEM_RD: mem_req=1, HADDR_Sel=1. On mem_ready → WB_MEM.
- MEM_WR: mem_req=1, HADDR_Sel=1, MemWrite=1. On mem_ready → FETCH, retire.
- WB_ALU: RegWrite=1, MemtoReg=0 → FETCH, retire.
- WB_MEM: RegWrite=1, MemtoReg=1 → FETCH, retire.
- EX_BR: ALUSrcA=1, ALUSrcB=0, ALUOp=1, PCSrc=1; BranchEQ=(funct==000), BranchNE=(funct==001) → FETCH, retire.
- EX_JAL: immediateSel=4, PCWrite=1, PCSrc=1 (target precomputed in DECODE with J-imm; DECODE uses immediateSel=4 when opCode=JAL), RegWrite=1 of oldPC+4 via ALUSrcA=2, ALUSrcB=2 → FETCH, retire.
- EX_JALR: PCWrite=1, PCSrc=2, immediateSel=0, RegWrite=1 (oldPC+4) → FETCH, retire.
- Latencies in cycles, with zero wait states:
  - R/I/AUIPC: 4
  - LW: 5
  - SW: 4
  - branch/JAL/JALR: 3
  - Each wait cycle adds 1.
- Wait counter: increments each cycle mem_req=1 and mem_ready=0; clears on mem_ready or state change. Reaching TIMEOUT_CYC → TRAP (cause 2), mem_req dropped the same edge.
- TRAP: all enables 0, trap=1. Stays until reset; trap_cause holds the first cause.
- retired: increments on the edge leaving a completing state; wraps modulo 2^CNT_W.
- mem_ready while mem_req=0: ignored.
- Reset asserted mid-transfer forces FETCH immediately; mem_req drops asynchronously.

Decomposition:
- Package cu_pkg holds:
  - state enum (4-bit)
  - opcode localparams (R, I, LW, SW, B, JAL, JALR, AUIPC)
  - funct3 BEQ/BNE
  - ALUOp, immediateSel, ALUSrcA/B, PCSrc encodings
  - trap cause codes
- One sub-module, cu_bus_watchdog: the wait counter plus timeout compare, parametrised by TIMEOUT_CYC.

Test Plan:
- Reset release, instruction word 0x00500093 (addi x1,x0,5), mem_ready always 1 → IRWrite at cycle 1, RegWrite=1 at cycle 4, retired=1.
- LW with mem_ready low 3 cycles in MEM_RD → MEM_RD held 4 cycles, HADDR_Sel=1 throughout, WB_MEM with MemtoReg=1, total 8 cycles.
- BNE (opCode 1100011, funct 001) → BranchNE=1, BranchEQ=0 in EX_BR; funct 100 → trap=1, trap_cause=1.
- Opcode 0000000 → TRAP after DECODE, all enables 0, state held over 10 further cycles.
- TIMEOUT_CYC=4, mem_ready never asserted in FETCH → trap_cause=2 at cycle 5, mem_req=0 afterwards.
- rst pulsed low during MEM_WR wait → MemWrite and mem_req drop without a clock edge; retired=0; FETCH restarts.
